filter_sched: RTL and testbench

- Frame-synchronous controller for the video filter bank. Turns debounced user buttons and an optional slideshow mode into the filter-select code and filter-enable that drive the filter mux.
- All changes are committed only at a vsync rising edge, so a filter never switches mid-frame.
- Sits between the user-input/debounce logic and the filter bank; its outputs replace direct per-button selection.

---
 rtl/filter_sched.sv | 113 +++++++++++
 tb/tb_filter_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sched.sv
// Frame-synchronous filter-select controller: captures button requests and the
// slideshow step, and commits them to the filter mux only at a vsync rising edge.
module filter_sched #(
    parameter int         FRAMES_PER_STEP = 60,
    parameter logic [1:0] INIT_FILTER     = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       user_in_en,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_toggle,
    input  logic       auto_mode,
    input  logic       vsync,
    output logic [1:0] filter,
    output logic       filters_en,
    output logic       pending,
    output logic [9:0] frame_cnt
);

    localparam logic [9:0] LAST_FRAME = 10'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT} state_t;

    state_t     r_state;
    logic       r_next_d, r_prev_d, r_tog_d, r_vs_d;
    logic [1:0] r_req_step;     // two's complement: 01 = +1, 11 = -1, 00 = none
    logic       r_req_tog;
    logic       r_auto;         // current COMMIT is a slideshow step, not a user request
    logic       r_pending;
    logic [1:0] r_filter;
    logic       r_en;
    logic [9:0] r_cnt;

    logic       w_next_e, w_prev_e, w_tog_e, w_vs_e;
    logic       w_active, w_clr;
    logic [1:0] w_step;
    logic       w_tog, w_pend;

    assign w_next_e = btn_next   & ~r_next_d & user_in_en;
    assign w_prev_e = btn_prev   & ~r_prev_d & user_in_en;
    assign w_tog_e  = btn_toggle & ~r_tog_d  & user_in_en;
    assign w_vs_e   = vsync      & ~r_vs_d;
    assign w_active = auto_mode & r_en;
    // A user commit consumes the held request; edges in the same cycle still land.
    assign w_clr    = (r_state == S_COMMIT) & ~r_auto;

    always_comb begin
        w_step = w_clr ? 2'b00 : r_req_step;
        if (w_next_e & ~w_prev_e)
            w_step = 2'b01;
        else if (w_prev_e & ~w_next_e)
            w_step = 2'b11;
        w_tog  = (w_clr ? 1'b0 : r_req_tog) ^ w_tog_e;
        w_pend = (w_step != 2'b00) | w_tog;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_next_d   <= btn_next;
            r_prev_d   <= btn_prev;
            r_tog_d    <= btn_toggle;
            r_vs_d     <= vsync;
            r_req_step <= 2'b00;
            r_req_tog  <= 1'b0;
            r_auto     <= 1'b0;
            r_pending  <= 1'b0;
            r_filter   <= INIT_FILTER;
            r_en       <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_next_d   <= btn_next;
            r_prev_d   <= btn_prev;
            r_tog_d    <= btn_toggle;
            r_vs_d     <= vsync;
            r_req_step <= w_step;
            r_req_tog  <= w_tog;
            r_pending  <= w_pend;
            case (r_state)
                S_COMMIT: begin
                    r_filter <= r_filter + (r_auto ? 2'd1 : r_req_step);
                    if (!r_auto && r_req_tog)
                        r_en <= ~r_en;
                    r_cnt   <= '0;
                    r_auto  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    if (w_vs_e && r_pending) begin
                        r_auto  <= 1'b0;
                        r_state <= S_COMMIT;
                    end else if (w_vs_e && w_active && r_cnt == LAST_FRAME) begin
                        r_auto  <= 1'b1;
                        r_state <= S_COMMIT;
                    end else begin
                        if (w_vs_e && w_active)
                            r_cnt <= r_cnt + 10'd1;
                        r_state <= w_pend ? S_WAIT : S_IDLE;
                    end
                end
            endcase
            if (!w_active)
                r_cnt <= '0;
        end
    end

    assign filter     = r_filter;
    assign filters_en = r_en;
    assign pending    = r_pending;
    assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_filter_sched.sv
// Directed bench for filter_sched: per-cycle comparison against a frame-level
// model, plus literal checks pinning the key scenarios.
module tb_filter_sched;

    localparam int         FPS  = 3;
    localparam logic [1:0] INIT = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       user_in_en = 1'b1;
    logic       btn_next = 1'b0, btn_prev = 1'b0, btn_toggle = 1'b0;
    logic       auto_mode = 1'b0, vsync = 1'b0;
    logic [1:0] filter;
    logic       filters_en, pending;
    logic [9:0] frame_cnt;

    int n_chk = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;
    int cyc_no = 0;

    filter_sched #(.FRAMES_PER_STEP(FPS), .INIT_FILTER(INIT)) dut (
        .clk(clk), .rst(rst), .user_in_en(user_in_en),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_toggle(btn_toggle),
        .auto_mode(auto_mode), .vsync(vsync),
        .filter(filter), .filters_en(filters_en), .pending(pending), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Model state: committed outputs, held request, and a commit scheduled by a vsync edge.
    int m_filter = 3, m_step = 0, m_cnt = 0;
    bit m_en = 1'b1, m_tog = 1'b0, m_apply = 1'b0, m_auto = 1'b0;
    bit p_n, p_p, p_t, p_v;
    bit e_n, e_p, e_t, e_v, act;

    always @(posedge clk) begin
        cyc_no++;
        if (!rst) begin
            m_filter = INIT; m_en = 1'b1; m_step = 0; m_tog = 1'b0; m_cnt = 0;
            m_apply = 1'b0; m_auto = 1'b0;
            p_n = btn_next; p_p = btn_prev; p_t = btn_toggle; p_v = vsync;
        end else begin
            e_n = btn_next & ~p_n & user_in_en;
            e_p = btn_prev & ~p_p & user_in_en;
            e_t = btn_toggle & ~p_t & user_in_en;
            e_v = vsync & ~p_v;
            p_n = btn_next; p_p = btn_prev; p_t = btn_toggle; p_v = vsync;
            act = auto_mode && m_en;
            if (m_apply) begin
                if (m_auto) begin
                    m_filter = (m_filter + 1) % 4;
                end else begin
                    m_filter = (m_filter + m_step + 4) % 4;
                    if (m_tog) m_en = ~m_en;
                    m_step = 0;
                    m_tog  = 1'b0;
                end
                m_cnt = 0;
                m_apply = 1'b0;
            end else if (e_v) begin
                if (m_step != 0 || m_tog) begin
                    m_apply = 1'b1; m_auto = 1'b0;
                end else if (act && m_cnt == FPS - 1) begin
                    m_apply = 1'b1; m_auto = 1'b1;
                end else if (act) begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (e_n && !e_p) m_step = 1;
            else if (e_p && !e_n) m_step = -1;
            if (e_t) m_tog = ~m_tog;
            if (!act) m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        logic [13:0] got, want;
        logic        mp;
        if (run_cmp) begin
            mp   = (m_step != 0) || m_tog;
            got  = {filter, filters_en, pending, frame_cnt};
            want = {m_filter[1:0], m_en, mp, m_cnt[9:0]};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL model_cmp cycle %0d: got f=%0d en=%0d pend=%0d cnt=%0d, want f=%0d en=%0d pend=%0d cnt=%0d",
                         cyc_no, got[13:12], got[11], got[10], got[9:0],
                         want[13:12], want[11], want[10], want[9:0]);
            end
        end
    end

    task automatic chk(input string nm, input int actual, input int expected);
        n_chk++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, actual, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 0 next, 1 prev, 2 toggle; two-cycle high pulse, two-cycle gap
    task automatic press(input int which);
        case (which)
            0: btn_next = 1'b1;
            1: btn_prev = 1'b1;
            default: btn_toggle = 1'b1;
        endcase
        cyc(2);
        btn_next = 1'b0; btn_prev = 1'b0; btn_toggle = 1'b0;
        cyc(2);
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        cyc(3);
        vsync = 1'b0;
        cyc(2);
    endtask

    initial begin
        // reset with btn_next held
        btn_next = 1'b1;
        @(negedge clk);
        run_cmp = 1'b1;
        cyc(2);
        chk("rst_filter", filter, 3);
        chk("rst_en", filters_en, 1);
        chk("rst_pending", pending, 0);
        chk("rst_cnt", frame_cnt, 0);
        rst = 1'b1;
        cyc(3);
        chk("held_btn_no_pend", pending, 0);
        btn_next = 1'b0;
        cyc(2);
        vs_pulse();
        chk("held_btn_no_commit", filter, 3);

        // single next, exact commit latency
        btn_next = 1'b1;
        cyc(1);
        chk("pend_after_edge", pending, 1);
        cyc(1);
        btn_next = 1'b0;
        cyc(3);
        chk("hold_mid_frame", filter, 3);
        vsync = 1'b1;
        cyc(1);
        chk("no_change_1cyc", filter, 3);
        cyc(1);
        chk("commit_wrap", filter, 0);
        chk("commit_pend_clr", pending, 0);
        cyc(1);
        vsync = 1'b0;
        cyc(3);

        // last request wins, 0-1 not accumulated
        press(1); press(1); press(0);
        vs_pulse();
        chk("last_wins", filter, 1);

        // toggle cancel / single toggle / restore
        press(2); press(2);
        chk("tog_cancel_pend", pending, 0);
        vs_pulse();
        chk("tog_cancel_en", filters_en, 1);
        press(2);
        chk("tog_pend", pending, 1);
        vs_pulse();
        chk("tog_en_off", filters_en, 0);
        press(2);
        vs_pulse();
        chk("tog_en_on", filters_en, 1);

        // slideshow from filter=2
        press(0);
        vs_pulse();
        chk("pre_auto_filter", filter, 2);
        auto_mode = 1'b1;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            vs_pulse();
            cyc(2);
        end
        chk("auto_step", filter, 3);
        chk("auto_cnt_clr", frame_cnt, 0);
        vs_pulse();
        chk("auto_cnt1", frame_cnt, 1);
        vs_pulse();
        chk("auto_cnt2", frame_cnt, 2);
        press(1);
        vs_pulse();
        chk("user_priority", filter, 2);
        chk("user_priority_cnt", frame_cnt, 0);
        auto_mode = 1'b0;
        cyc(2);

        // gating: held request survives user_in_en falling; new edges ignored
        press(0);
        user_in_en = 1'b0;
        cyc(1);
        chk("gated_kept_pend", pending, 1);
        vs_pulse();
        chk("gated_kept_commit", filter, 3);
        press(0);
        chk("gated_edge_ignored", pending, 0);

        // reset while a request waits
        user_in_en = 1'b1;
        press(1);
        user_in_en = 1'b0;
        chk("wait_pend", pending, 1);
        rst = 1'b0;
        cyc(1);
        chk("midwait_rst_filter", filter, 3);
        chk("midwait_rst_pend", pending, 0);
        cyc(1);
        rst = 1'b1;
        cyc(2);
        vs_pulse();
        cyc(1);
        chk("post_rst_filter", filter, 3);
        chk("post_rst_pend", pending, 0);

        cyc(2);
        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
